// File: rtl/squeeze_layer_sequencer.sv
// rtl/squeeze_layer_sequencer.sv - address/strobe sequencer for one squeeze conv layer
// Streams IFM/ROM addresses per tap and emits MAC clear and OFM write strobes per pixel.
module squeeze_layer_sequencer #(
    parameter int WOUT       = 8,
    parameter int CHIN       = 384,
    parameter int KERNEL_DIM = 3,
    parameter int MAC_LAT    = 2,
    localparam int TAPS      = KERNEL_DIM * KERNEL_DIM * CHIN,
    localparam int PIX       = WOUT * WOUT,
    localparam int TW        = $clog2(TAPS),
    localparam int PW        = $clog2(PIX),
    localparam int AW        = $clog2(TAPS * PIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic          ram_feedback,
    output logic          layer_en,
    output logic [AW-1:0] ifm_addr,
    output logic [TW-1:0] rom_addr,
    output logic          clr_pulse,
    output logic          sample,
    output logic [PW-1:0] ofm_wr_addr,
    output logic          busy,
    output logic          finish
);
    localparam int DW = $clog2(MAC_LAT + 1);
    localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
    localparam logic [PW-1:0] PIX_LAST   = PW'(PIX - 1);
    localparam logic [AW-1:0] TAPS_A     = AW'(TAPS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [PW-1:0]        pix_q, pix_d;
    logic [PW-1:0]        ofm_q, ofm_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [MAC_LAT-1:0]   pipe_q, pipe_d;
    logic                 sample_q, sample_d;
    logic                 last_tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            pix_q    <= '0;
            ofm_q    <= '0;
            drain_q  <= '0;
            pipe_q   <= '0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            pix_q    <= pix_d;
            ofm_q    <= ofm_d;
            drain_q  <= drain_d;
            pipe_q   <= pipe_d;
            sample_q <= sample_d;
        end
    end

    assign layer_en    = (state_q == S_RUN) && !hold;
    assign last_tap    = (tap_q == TAP_LAST) && layer_en;
    // Product term kept at full AW width so pix*TAPS never truncates.
    assign ifm_addr    = AW'(pix_q) * TAPS_A + AW'(tap_q);
    assign rom_addr    = tap_q;
    assign clr_pulse   = pipe_q[MAC_LAT-1];
    assign sample      = sample_q;
    assign ofm_wr_addr = sample_q ? ofm_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign finish      = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        pix_d    = pix_q;
        ofm_d    = ofm_q;
        drain_d  = drain_q;
        pipe_d   = '0;
        sample_d = pipe_q[MAC_LAT-1];

        pipe_d[0] = last_tap;
        for (int i = 1; i < MAC_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (sample_q) begin
            ofm_d = ofm_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    tap_d   = '0;
                    pix_d   = '0;
                    ofm_d   = '0;
                end
            end
            S_RUN: begin
                if (layer_en) begin
                    if (tap_q == TAP_LAST) begin
                        tap_d = '0;
                        if (pix_q == PIX_LAST) begin
                            pix_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            pix_d = pix_q + PW'(1);
                        end
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Stay long enough for the final clear and its sample to leave the pipe.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                if (ram_feedback) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_squeeze_layer_sequencer.sv
// tb/tb_squeeze_layer_sequencer.sv - self-checking bench for squeeze_layer_sequencer
module tb_squeeze_layer_sequencer;
    localparam int WOUT = 2, CHIN = 2, KD = 1, MAC_LAT = 2;
    localparam int TAPS = KD * KD * CHIN;
    localparam int PIX  = WOUT * WOUT;
    localparam int N    = TAPS * PIX;
    localparam int TW   = $clog2(TAPS);
    localparam int PW   = $clog2(PIX);
    localparam int AW   = $clog2(N);
    localparam int TLEN = 34;

    logic          clk = 1'b0;
    logic          rst, start, hold, ram_feedback;
    logic          layer_en, clr_pulse, sample, busy, finish;
    logic [AW-1:0] ifm_addr;
    logic [TW-1:0] rom_addr;
    logic [PW-1:0] ofm_wr_addr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic start, fb, le, clr, smp, busy, fin;
        int   ifm, rom, ofm;
    } vec_t;
    vec_t tbl[TLEN];

    squeeze_layer_sequencer #(
        .WOUT(WOUT), .CHIN(CHIN), .KERNEL_DIM(KD), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .ram_feedback(ram_feedback),
        .layer_en(layer_en), .ifm_addr(ifm_addr), .rom_addr(rom_addr),
        .clr_pulse(clr_pulse), .sample(sample), .ofm_wr_addr(ofm_wr_addr),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " layer_en"}, int'(layer_en), 0);
        chk({tag, " ifm_addr"}, int'(ifm_addr), 0);
        chk({tag, " rom_addr"}, int'(rom_addr), 0);
        chk({tag, " clr_pulse"}, int'(clr_pulse), 0);
        chk({tag, " sample"}, int'(sample), 0);
        chk({tag, " ofm_wr_addr"}, int'(ofm_wr_addr), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " finish"}, int'(finish), 0);
    endtask

    task automatic apply_table(input string tag);
        for (int c = 0; c < TLEN; c++) begin
            @(posedge clk); #1;
            start = tbl[c].start; ram_feedback = tbl[c].fb; hold = 1'b0;
            @(negedge clk);
            chk($sformatf("%s c%0d layer_en", tag, c), int'(layer_en), int'(tbl[c].le));
            if (tbl[c].le) begin
                chk($sformatf("%s c%0d ifm_addr", tag, c), int'(ifm_addr), tbl[c].ifm);
                chk($sformatf("%s c%0d rom_addr", tag, c), int'(rom_addr), tbl[c].rom);
            end
            chk($sformatf("%s c%0d clr_pulse", tag, c), int'(clr_pulse), int'(tbl[c].clr));
            chk($sformatf("%s c%0d sample", tag, c), int'(sample), int'(tbl[c].smp));
            if (tbl[c].smp)
                chk($sformatf("%s c%0d ofm_wr_addr", tag, c), int'(ofm_wr_addr), tbl[c].ofm);
            chk($sformatf("%s c%0d busy", tag, c), int'(busy), int'(tbl[c].busy));
            chk($sformatf("%s c%0d finish", tag, c), int'(finish), int'(tbl[c].fin));
        end
        @(posedge clk); #1;
        start = 1'b0; ram_feedback = 1'b0;
    endtask

    // Reference model: the k-th issued tap reads IFM word k; a pixel's last tap
    // clears MAC_LAT cycles later and is written one cycle after that.
    task automatic run_layer(input string tag, input int hold_pct, input bit spurious,
                             input int hold_from, input int hold_to,
                             input int ack_delay, input bit start_with_ack);
        int k = 0, last = -1, acked = -1, nsmp = 0, c;
        int clr_t[$], smp_t[$], smp_a[$];
        bit inrun, fin_exp, exp_clr, exp_smp, exp_le;
        for (c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            inrun   = (c >= 1) && (k < N);
            fin_exp = (last >= 0) && (c >= last + MAC_LAT + 2) && (acked < 0);
            start   = (c == 0) || (spurious && acked < 0 && $urandom_range(0, 3) == 0);
            if (inrun)
                hold = (c >= hold_from && c <= hold_to) || ($urandom_range(0, 99) < hold_pct);
            else
                hold = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            ram_feedback = (spurious && !fin_exp && acked < 0) ? ($urandom_range(0, 4) == 0) : 1'b0;
            if (fin_exp && c == last + MAC_LAT + 2 + ack_delay) begin
                ram_feedback = 1'b1;
                start        = start_with_ack;
            end
            if (acked >= 0) start = 1'b0;
            exp_le  = inrun && !hold;
            exp_clr = (clr_t.size() > 0) && (clr_t[0] == c);
            exp_smp = (smp_t.size() > 0) && (smp_t[0] == c);
            @(negedge clk);
            chk($sformatf("%s c%0d layer_en", tag, c), int'(layer_en), int'(exp_le));
            if (inrun) begin
                chk($sformatf("%s c%0d ifm_addr", tag, c), int'(ifm_addr), k);
                chk($sformatf("%s c%0d rom_addr", tag, c), int'(rom_addr), k % TAPS);
            end
            chk($sformatf("%s c%0d clr_pulse", tag, c), int'(clr_pulse), int'(exp_clr));
            chk($sformatf("%s c%0d sample", tag, c), int'(sample), int'(exp_smp));
            if (sample) nsmp++;
            if (exp_clr) void'(clr_t.pop_front());
            if (exp_smp) begin
                chk($sformatf("%s c%0d ofm_wr_addr", tag, c), int'(ofm_wr_addr), smp_a[0]);
                void'(smp_t.pop_front());
                void'(smp_a.pop_front());
            end
            chk($sformatf("%s c%0d busy", tag, c), int'(busy),
                int'((c >= 1) && !(acked >= 0 && c > acked)));
            chk($sformatf("%s c%0d finish", tag, c), int'(finish), int'(fin_exp));
            if (ram_feedback && fin_exp) acked = c;
            if (exp_le) begin
                if (k % TAPS == TAPS - 1) begin
                    clr_t.push_back(c + MAC_LAT);
                    smp_t.push_back(c + MAC_LAT + 1);
                    smp_a.push_back(k / TAPS);
                end
                k++;
                if (k == N) last = c;
            end
            if (acked >= 0 && c == acked + 2) break;
        end
        chk({tag, " layer acknowledged"}, int'(acked >= 0), 1);
        chk({tag, " sample count"}, nsmp, PIX);
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; ram_feedback = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < TLEN; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].fb    = (c == 32);
            tbl[c].le    = (c >= 1 && c <= 8);
            tbl[c].ifm   = c - 1;
            tbl[c].rom   = (c - 1) % 2;
            tbl[c].clr   = (c >= 4 && c <= 10 && c % 2 == 0);
            tbl[c].smp   = (c >= 5 && c <= 11 && c % 2 == 1);
            tbl[c].ofm   = (c - 5) / 2;
            tbl[c].busy  = (c >= 1 && c <= 32);
            tbl[c].fin   = (c >= 12 && c <= 32);
        end

        rst = 1'b1; start = 1'b0; hold = 1'b0; ram_feedback = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        apply_table("nominal");
        apply_table("repeat");

        run_layer("hold3to5", 0, 1'b0, 3, 5, 0, 1'b0);
        run_layer("spurious", 0, 1'b1, -1, -1, 3, 1'b1);
        run_layer("model_nom", 0, 1'b0, -1, -1, 0, 1'b0);

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrun_reset");
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset c%0d clr_pulse", c), int'(clr_pulse), 0);
            chk($sformatf("post_reset c%0d sample", c), int'(sample), 0);
            chk($sformatf("post_reset c%0d busy", c), int'(busy), 0);
        end
        run_layer("after_reset", 0, 1'b0, -1, -1, 1, 1'b0);

        for (int r = 0; r < 8; r++)
            run_layer($sformatf("rand%0d", r), 35, 1'b1, -1, -1,
                      int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
